// File: rtl/iteration_vector_generator_csg.sv
// Odometer-style iteration vector generator: walks an N-dimensional signed
// rectangular space from latched lower to upper bounds, one point per step.
module iteration_vector_generator_csg #(
    parameter int ITERATION_VARIABLE_WIDTH = 16,
    parameter int NUM_DIMENSIONS           = 3
) (
    input  logic                                             clk,
    input  logic                                             reset,
    input  logic                                             start,
    input  logic                                             step,
    input  logic                                             abort,
    input  logic [NUM_DIMENSIONS*ITERATION_VARIABLE_WIDTH-1:0] bound_lo,
    input  logic [NUM_DIMENSIONS*ITERATION_VARIABLE_WIDTH-1:0] bound_hi,
    output logic [NUM_DIMENSIONS*ITERATION_VARIABLE_WIDTH-1:0] ivar,
    output logic                                             valid,
    output logic                                             last,
    output logic                                             done,
    output logic                                             busy,
    output logic                                             cfg_error
);
    localparam int W = ITERATION_VARIABLE_WIDTH;
    localparam int N = NUM_DIMENSIONS;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t         state_reg;
    logic [N*W-1:0] lo_reg;
    logic [N*W-1:0] hi_reg;
    logic [N*W-1:0] ivar_reg;
    logic [N*W-1:0] ivar_next;
    logic           cfg_error_reg;

    logic [N-1:0]   at_hi;
    logic [N-1:0]   carry;
    logic [N-1:0]   bad_cfg;
    logic           last_point;

    assign carry[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_dim
            assign at_hi[gi]   = (ivar_reg[gi*W +: W] == hi_reg[gi*W +: W]);
            assign bad_cfg[gi] = ($signed(bound_lo[gi*W +: W]) > $signed(bound_hi[gi*W +: W]));
            // Increment only below hi, otherwise reload lo: no overflow at the signed maximum.
            assign ivar_next[gi*W +: W] = !carry[gi] ? ivar_reg[gi*W +: W] :
                                          at_hi[gi]  ? lo_reg[gi*W +: W]   :
                                          ivar_reg[gi*W +: W] + {{(W-1){1'b0}}, 1'b1};
            if (gi < N-1) begin : g_carry
                assign carry[gi+1] = carry[gi] & at_hi[gi];
            end
        end
    endgenerate

    assign last_point = &at_hi;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            lo_reg        <= '0;
            hi_reg        <= '0;
            ivar_reg      <= '0;
            cfg_error_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        lo_reg <= bound_lo;
                        hi_reg <= bound_hi;
                        if (|bad_cfg) begin
                            state_reg     <= FIN;
                            cfg_error_reg <= 1'b1;
                        end else begin
                            state_reg     <= RUN;
                            ivar_reg      <= bound_lo;
                            cfg_error_reg <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        state_reg <= IDLE;
                    end else if (step) begin
                        // The final point is held rather than wrapped back to lo.
                        if (last_point) begin
                            state_reg <= FIN;
                        end else begin
                            ivar_reg <= ivar_next;
                        end
                    end
                end
                FIN: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign ivar      = ivar_reg;
    assign valid     = (state_reg == RUN);
    assign last      = (state_reg == RUN) && last_point;
    assign done      = (state_reg == FIN);
    assign busy      = (state_reg != IDLE);
    assign cfg_error = cfg_error_reg;

endmodule

// File: tb/tb_iteration_vector_generator_csg.sv
// Bench for iteration_vector_generator_csg with N=2, W=16: scoreboard of
// expected (ivar, last) points, one scenario task per feature.
module tb_iteration_vector_generator_csg;
    localparam int W = 16;
    localparam int N = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic           step;
    logic           abort;
    logic [N*W-1:0] bound_lo;
    logic [N*W-1:0] bound_hi;
    logic [N*W-1:0] ivar;
    logic           valid;
    logic           last;
    logic           done;
    logic           busy;
    logic           cfg_error;

    typedef struct packed {
        logic [N*W-1:0] ivar;
        logic           last;
    } exp_t;

    exp_t sb[$];
    int   applied = 0;
    int   errors  = 0;

    always #5 clk = ~clk;

    iteration_vector_generator_csg #(
        .ITERATION_VARIABLE_WIDTH(W),
        .NUM_DIMENSIONS(N)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .step(step),
        .abort(abort),
        .bound_lo(bound_lo),
        .bound_hi(bound_hi),
        .ivar(ivar),
        .valid(valid),
        .last(last),
        .done(done),
        .busy(busy),
        .cfg_error(cfg_error)
    );

    function automatic logic [N*W-1:0] pk(input int d0, input int d1);
        return {16'(d1), 16'(d0)};
    endfunction

    function automatic exp_t pt(input int d0, input int d1, input logic l);
        exp_t e;
        e.ivar = pk(d0, d1);
        e.last = l;
        return e;
    endfunction

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; step = 1'b0; abort = 1'b0;
        bound_lo = '0; bound_hi = '0;
        repeat (2) @(negedge clk);
        applied++;
        if ({ivar, valid, last, done, busy, cfg_error} !== {{(N*W){1'b0}}, 5'b0}) begin
            errors++;
            $display("FAIL reset_state: ivar=%h v=%b l=%b d=%b b=%b e=%b, required all zero",
                     ivar, valid, last, done, busy, cfg_error);
        end
        reset = 1'b0;
        @(negedge clk);
        applied++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: busy=%b valid=%b, required 0 0", busy, valid);
        end
    endtask

    // Expected points must already be queued; step is held high throughout.
    task automatic test_held_walk(input string name, input logic [N*W-1:0] lo, input logic [N*W-1:0] hi);
        exp_t e;
        bound_lo = lo; bound_hi = hi; start = 1'b1;
        @(negedge clk);
        start = 1'b0; step = 1'b1;
        bound_lo = '1; bound_hi = '0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            applied++;
            if (valid !== 1'b1 || ivar !== e.ivar || last !== e.last) begin
                errors++;
                $display("FAIL %s_point: valid=%b ivar=%h last=%b, required valid=1 ivar=%h last=%b",
                         name, valid, ivar, last, e.ivar, e.last);
            end
            @(negedge clk);
        end
        applied++;
        if (done !== 1'b1 || valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_done: done=%b valid=%b, required 1 0", name, done, valid);
        end
        step = 1'b0;
        @(negedge clk);
        applied++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle: busy=%b done=%b, required 0 0", name, busy, done);
        end
    endtask

    task automatic test_odometer();
        sb.push_back(pt(0, 0, 1'b0)); sb.push_back(pt(1, 0, 1'b0)); sb.push_back(pt(2, 0, 1'b0));
        sb.push_back(pt(0, 1, 1'b0)); sb.push_back(pt(1, 1, 1'b0)); sb.push_back(pt(2, 1, 1'b1));
        test_held_walk("odometer", pk(0, 0), pk(2, 1));
    endtask

    task automatic test_boundary();
        sb.push_back(pt(32765, 0, 1'b0)); sb.push_back(pt(32766, 0, 1'b0)); sb.push_back(pt(32767, 0, 1'b0));
        sb.push_back(pt(32765, 1, 1'b0)); sb.push_back(pt(32766, 1, 1'b0)); sb.push_back(pt(32767, 1, 1'b1));
        test_held_walk("boundary", pk(32765, 0), pk(32767, 1));
    endtask

    // Step every other cycle; each driven cycle pushes what the next cycle must show.
    task automatic test_signed_toggle();
        exp_t e;
        int   d0;
        bound_lo = pk(-2, 5); bound_hi = pk(1, 5); start = 1'b1;
        sb.push_back(pt(-2, 5, 1'b0));
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            e = sb.pop_front();
            applied++;
            if (valid !== 1'b1 || ivar !== e.ivar || last !== e.last) begin
                errors++;
                $display("FAIL signed_cycle%0d: valid=%b ivar=%h last=%b, required valid=1 ivar=%h last=%b",
                         i, valid, ivar, last, e.ivar, e.last);
            end
            step = i[0];
            d0 = -2 + (i + 1) / 2;
            if (i < 7) sb.push_back(pt(d0, 5, (d0 == 1)));
            @(negedge clk);
        end
        step = 1'b0;
        applied++;
        if (done !== 1'b1 || valid !== 1'b0 || ivar !== pk(1, 5)) begin
            errors++;
            $display("FAIL signed_done: done=%b valid=%b ivar=%h, required 1 0 %h", done, valid, ivar, pk(1, 5));
        end
        @(negedge clk);
    endtask

    task automatic test_single_point();
        bound_lo = pk(7, 7); bound_hi = pk(7, 7); start = 1'b1;
        @(negedge clk);
        applied++;
        if (valid !== 1'b1 || last !== 1'b1 || ivar !== pk(7, 7)) begin
            errors++;
            $display("FAIL single_first: valid=%b last=%b ivar=%h, required 1 1 %h", valid, last, ivar, pk(7, 7));
        end
        bound_lo = pk(0, 0); bound_hi = pk(3, 3);
        @(negedge clk);
        applied++;
        if (valid !== 1'b1 || last !== 1'b1 || ivar !== pk(7, 7)) begin
            errors++;
            $display("FAIL single_start_busy: valid=%b last=%b ivar=%h, required 1 1 %h", valid, last, ivar, pk(7, 7));
        end
        start = 1'b0; step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        applied++;
        if (done !== 1'b1 || valid !== 1'b0) begin
            errors++;
            $display("FAIL single_done: done=%b valid=%b, required 1 0", done, valid);
        end
        @(negedge clk);
    endtask

    task automatic test_cfg_error();
        bound_lo = pk(3, 0); bound_hi = pk(2, 0); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        applied++;
        if (done !== 1'b1 || cfg_error !== 1'b1 || valid !== 1'b0) begin
            errors++;
            $display("FAIL cfg_err_done: done=%b cfg_error=%b valid=%b, required 1 1 0", done, cfg_error, valid);
        end
        @(negedge clk);
        applied++;
        if (busy !== 1'b0 || cfg_error !== 1'b1 || valid !== 1'b0) begin
            errors++;
            $display("FAIL cfg_err_sticky: busy=%b cfg_error=%b valid=%b, required 0 1 0", busy, cfg_error, valid);
        end
        bound_lo = pk(0, 0); bound_hi = pk(0, 0); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        applied++;
        if (cfg_error !== 1'b0 || valid !== 1'b1) begin
            errors++;
            $display("FAIL cfg_err_clear: cfg_error=%b valid=%b, required 0 1", cfg_error, valid);
        end
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_abort_and_reset();
        bound_lo = pk(0, 0); bound_hi = pk(2, 1); start = 1'b1;
        @(negedge clk);
        start = 1'b0; step = 1'b1;
        @(negedge clk);
        applied++;
        if (ivar !== pk(1, 0)) begin
            errors++;
            $display("FAIL abort_setup: ivar=%h, required %h", ivar, pk(1, 0));
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0; step = 1'b0;
        applied++;
        if (busy !== 1'b0 || valid !== 1'b0 || done !== 1'b0 || ivar !== pk(1, 0)) begin
            errors++;
            $display("FAIL abort_idle: busy=%b valid=%b done=%b ivar=%h, required 0 0 0 %h",
                     busy, valid, done, ivar, pk(1, 0));
        end
        @(negedge clk);
        applied++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done: done=%b, required 0", done);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; step = 1'b1;
        repeat (4) @(negedge clk);
        applied++;
        if (ivar !== pk(1, 1) || valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_setup: ivar=%h valid=%b, required %h 1", ivar, valid, pk(1, 1));
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; step = 1'b0;
        applied++;
        if ({ivar, valid, last, done, busy, cfg_error} !== {{(N*W){1'b0}}, 5'b0}) begin
            errors++;
            $display("FAIL midrun_reset: ivar=%h v=%b l=%b d=%b b=%b e=%b, required all zero",
                     ivar, valid, last, done, busy, cfg_error);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_odometer();
        test_signed_toggle();
        test_single_point();
        test_cfg_error();
        test_abort_and_reset();
        test_boundary();
        $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
        $finish;
    end

endmodule

// File: doc/iteration_vector_generator_csg.md
# iteration_vector_generator_csg

Sequential generator for the global controller's iteration vector. It walks an N-dimensional rectangular iteration space from per-dimension lower to upper bounds, one point per accepted step. The `ivar` values it produces feed the program-block range comparators downstream. Dimension 0 is the innermost loop.

## Interface
- `ITERATION_VARIABLE_WIDTH`, 16, width W of each signed iteration variable.
- `NUM_DIMENSIONS`, 3, number of loop dimensions N (≥1).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  pulse; latch bounds and begin a run (honoured only in IDLE).
- `step`  in  1  advance to next iteration (honoured only while `valid`=1).
- `abort`  in  1  terminate current run without `done`.
- `bound_lo`  in  N*W  signed lower bounds; dim d at bits [d*W +: W].
- `bound_hi`  in  N*W  signed upper bounds (inclusive), same packing.
- `ivar`  out  N*W  current iteration vector, same packing.
- `valid`  out  1  `ivar` holds a live iteration point.
- `last`  out  1  `valid` and every dim equals its latched upper bound.
- `done`  out  1  one-cycle pulse at normal completion or config error.
- `busy`  out  1  state ≠ IDLE.
- `cfg_error`  out  1  some `bound_lo[d]` > `bound_hi[d]` at the last start; sticky until next accepted start.

## Operation
- States: IDLE, RUN, FIN.
- IDLE:
  - `start`=1 latches both bound buses into internal registers. Later input changes do not affect the run.
  - If all lo ≤ hi (signed): go to RUN, `ivar` ← lo, `cfg_error` ← 0.
  - Otherwise: go to FIN, `cfg_error` ← 1, `ivar` unchanged.
- RUN: `valid`=1.
  - On `step`, dim 0 increments.
  - A dim equal to its hi wraps to its lo and carries into the next dim (odometer order).
  - `step` with `last`=1: go to FIN, `ivar` holds the final point.
  - Without `step`, `ivar` holds.
- FIN: `done`=1, `valid`=0 for exactly one cycle, then IDLE.
- `abort` in RUN or FIN: go to IDLE next edge. `done` is not asserted; `ivar` holds.
- `abort` in IDLE: no effect. `start` in IDLE with `abort` in the same cycle: `start` wins.
- `step` and `abort` together in RUN: `abort` wins, no advance.
- `start` while busy: ignored. `step` while `valid`=0: ignored.
- Arithmetic:
  - Signed compares on W bits.
  - The increment is applied only when the dim is below hi, so no overflow occurs, even at hi = 2^(W-1)-1.
  - The wrap reloads lo; there is no modular arithmetic.
- `last`: combinational from the registered `ivar` and latched hi, gated by `valid`.

## Timing
- Reset values (next edge after `reset`=1): state IDLE, `ivar`=0, `valid`=0, `last`=0, `done`=0, `busy`=0, `cfg_error`=0, latched bounds=0.
- Reset overrides all inputs, including mid-run.
- `start` at edge k: `valid`=1 and `ivar`=lo from cycle k+1.
- `step` sampled at edge k: new `ivar` visible in cycle k+1. Throughput is one point per cycle with `step` held high.
- A P-point space with continuous `step` gives `valid` for P cycles, then `done` on cycle P+1 after start, then IDLE.
- The earliest next accepted `start` is in the cycle after `done`.
- Config error: `done` and `cfg_error` are both high in the cycle after `start`. `valid` is never asserted.

## Test plan
- N=2, W=16, lo=(0,0), hi=(2,1), `start`, then `step` held high:
  - `ivar` (d0,d1) = (0,0),(1,0),(2,0),(0,1),(1,1),(2,1).
  - `last` high only on (2,1).
  - `done` pulse in the next cycle, then `busy`=0.
- Signed bounds: dim0 lo=-2, hi=1; dim1 lo=hi=5; `step` toggled every other cycle:
  - d0 = -2,-1,0,1 with d1=5 throughout.
  - `ivar` holds during idle cycles.
  - `done` appears one cycle after the step on d0=1.
- Single point, all lo=hi=7: `valid` and `last` are high in the first RUN cycle; one `step` → `done`. `start` while busy is ignored.
- Config error, lo0=3, hi0=2: next cycle `done`=1 and `cfg_error`=1 with `valid`=0. A subsequent valid `start` clears `cfg_error`.
- Mid-run `abort` with simultaneous `step` at (1,0) of test 1:
  - No advance, IDLE next cycle, no `done`.
  - Repeat the run with `reset` at (1,1): all outputs return to reset values.
- Boundary, W=16, dim0 lo=32765, hi=32767: d0 = 32765,32766,32767, then wraps to 32765 with carry. No negative value ever appears.
